// File: rtl/simplez_pkg.sv
// Shared SIMPLEZ peripheral definitions: bus widths, address map, UART TX state encoding.
// The TX_PARITY state exists only when SIMPLEZ_UART_PARITY_EN is defined.
package simplez_pkg;

    localparam int DATAW_DEF = 12;
    localparam int ADDRW_DEF = 9;

    localparam logic [8:0] LEDS_ADDR      = 9'o100;
    localparam logic [8:0] UART_DATA_ADDR = 9'o101;
    localparam logic [8:0] UART_STAT_ADDR = 9'o102;

    localparam int STAT_READY = 0;
    localparam int STAT_OVR   = 1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef SIMPLEZ_UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/simplez_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, tick on the last count.
// Updates on the falling clock edge like the rest of the SIMPLEZ datapath.
module simplez_baud_gen #(
    parameter int CLK_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simplez_uart_tx.sv
// SIMPLEZ memory-mapped UART transmitter: data register at BASE_ADDR, status at BASE_ADDR+1.
// Define SIMPLEZ_UART_PARITY_EN to append an even-parity bit (8E1 frame of 11 bit periods).
module simplez_uart_tx
    import simplez_pkg::*;
#(
    parameter int               DATAW     = DATAW_DEF,
    parameter int               ADDRW     = ADDRW_DEF,
    parameter logic [ADDRW-1:0] BASE_ADDR = UART_DATA_ADDR,
    parameter int               CLK_DIV   = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDRW-1:0] addr,
    input  logic             wr,
    input  logic             rd,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             tx,
    output logic             busy
);

    localparam logic [ADDRW-1:0] STAT_ADDR = BASE_ADDR + ADDRW'(1);

    tx_state_e  state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;

    logic       cs_data, cs_stat;
    logic       accept, ovr_set, ovr_clr;
    logic       tick;
    logic [2:0] bit_nx;
    logic       unused_data_hi;

    assign cs_data = (addr == BASE_ADDR);
    assign cs_stat = (addr == STAT_ADDR);

    // busy_q is the registered flag, so a write on the edge busy falls is still an overrun.
    assign accept  = wr && cs_data && !busy_q;
    assign ovr_set = wr && cs_data && busy_q;
    assign ovr_clr = rd && cs_stat;

    assign bit_nx         = bit_q + 3'd1;
    assign unused_data_hi = ^data_in[DATAW-1:8];

    simplez_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state_q != TX_IDLE),
        .tick(tick)
    );

    always_comb begin
        data_out = '0;
        if (cs_data) begin
            data_out[7:0] = hold_q;
        end else if (cs_stat) begin
            data_out[STAT_READY] = ~busy_q;
            data_out[STAT_OVR]   = ovr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        // A set and a clear on the same edge leave the overrun flag set.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    state_d = TX_START;
                    hold_d  = data_in[7:0];
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    tx_d    = hold_q[0];
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef SIMPLEZ_UART_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = ^hold_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = hold_q[bit_nx];
                    end
                end
            end
`ifdef SIMPLEZ_UART_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            bit_q   <= 3'd0;
            hold_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Randomized bench for simplez_uart_tx against a frame-queue reference model (CLK_DIV=4).
module tb_simplez_uart_tx;

    localparam int CD = 4;
    localparam int DW = 12;
    localparam int AW = 9;
    localparam logic [AW-1:0] A_LED  = 9'o100;
    localparam logic [AW-1:0] A_DATA = 9'o101;
    localparam logic [AW-1:0] A_STAT = 9'o102;
    localparam logic [AW-1:0] A_HOLE = 9'o103;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          tx;
    logic          busy;

    always #5 clk = ~clk;

    simplez_uart_tx #(
        .DATAW    (DW),
        .ADDRW    (AW),
        .BASE_ADDR(A_DATA),
        .CLK_DIV  (CD)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .data_in (data_in),
        .data_out(data_out),
        .tx      (tx),
        .busy    (busy)
    );

    // Reference model: one queue entry per clock cycle of line output still to come.
    int         checks = 0;
    int         failures = 0;
    logic       exp_q[$];
    logic [7:0] m_hold = 8'd0;
    logic       m_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef SIMPLEZ_UART_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < CD; j++) exp_q.push_back(bits[k]);
        end
    endtask

    function automatic logic [DW-1:0] exp_dout(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = '0;
        if (a == A_DATA) begin
            r[7:0] = m_hold;
        end else if (a == A_STAT) begin
            r[0] = (exp_q.size() == 0);
            r[1] = m_ovr;
        end
        return r;
    endfunction

    task automatic model_edge(input logic [AW-1:0] a, input logic w, input logic r,
                              input logic [DW-1:0] d);
        logic busy_before;
        logic set_o;
        busy_before = (exp_q.size() != 0);
        if (busy_before) void'(exp_q.pop_front());
        set_o = w && (a == A_DATA) && busy_before;
        if (w && (a == A_DATA) && !busy_before) begin
            m_hold = d[7:0];
            push_frame(d[7:0]);
        end
        if (set_o) m_ovr = 1'b1;
        else if (r && (a == A_STAT)) m_ovr = 1'b0;
    endtask

    // One bus cycle: drive after the rising edge, state moves on the falling edge.
    task automatic step(input logic [AW-1:0] a, input logic w, input logic r,
                        input logic [DW-1:0] d, input int want = -1);
        @(posedge clk);
        addr = a; wr = w; rd = r; data_in = d;
        #1;
        check("dout", 32'(data_out), 32'(exp_dout(a)));
        if (want >= 0) check("dout_const", 32'(data_out), want);
        @(negedge clk);
        model_edge(a, w, r, d);
        #1;
        check("tx", 32'(tx), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd1);
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(9'o000, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        wr = 1'b0; rd = 1'b0; addr = A_STAT;
        rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        m_hold = 8'd0;
        m_ovr  = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
    endtask

    int frame_len;

    initial begin
`ifdef SIMPLEZ_UART_PARITY_EN
        frame_len = 11 * CD;
`else
        frame_len = 10 * CD;
`endif
        repeat (2) @(posedge clk);
        addr = A_STAT;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stat", 32'(data_out), 32'h001);
        @(posedge clk);
        rst = 1'b0;

        // Basic frame, mid-frame status, overrun during frame.
        step(A_DATA, 1'b1, 1'b0, 12'h055);
        idle(8);
        step(A_STAT, 1'b0, 1'b0, '0, 12'h000);
        step(A_DATA, 1'b1, 1'b0, 12'h0AA);
        step(A_STAT, 1'b0, 1'b0, '0, 12'h002);
        idle(frame_len);
        step(A_STAT, 1'b0, 1'b0, '0, 12'h003);
        step(A_STAT, 1'b0, 1'b1, '0, 12'h003);
        step(A_STAT, 1'b0, 1'b0, '0, 12'h001);
        step(A_DATA, 1'b0, 1'b1, '0, 12'h055);

        // Write exactly on the edge busy falls is an overrun; the next cycle is accepted.
        step(A_DATA, 1'b1, 1'b0, 12'h011);
        idle(frame_len - 1);
        step(A_DATA, 1'b1, 1'b1, 12'h022);
        step(A_STAT, 1'b0, 1'b0, '0, 12'h003);
        step(A_DATA, 1'b1, 1'b0, 12'h033);
        idle(frame_len + 2);

        // Unmapped and status-address writes, then upper data bits ignored.
        step(A_LED, 1'b1, 1'b0, 12'h0FF, 0);
        step(A_HOLE, 1'b1, 1'b0, 12'h0FF, 0);
        step(A_STAT, 1'b1, 1'b0, 12'h0FF);
        step(A_DATA, 1'b1, 1'b0, 12'hF3C);
        idle(frame_len + 1);
        step(A_DATA, 1'b0, 1'b0, '0, 12'h03C);

        // Reset in the middle of a frame.
        step(A_DATA, 1'b1, 1'b0, 12'h000);
        idle(14);
        do_reset();
        step(A_STAT, 1'b0, 1'b0, '0, 12'h001);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: a = A_LED;
                1, 2, 3: a = A_DATA;
                4, 5: a = A_STAT;
                6: a = A_HOLE;
                default: a = AW'($urandom_range(0, 511));
            endcase
            step(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 DW'($urandom_range(0, 4095)));
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        idle(frame_len + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
